hscan_ctrl: RTL and testbench
=============================

HSCAN_CTRL -- requirements
Module: hscan_ctrl

Interface
REQ-001 Parameter H_SYNC, default 72: horizontal sync width in pixel clocks.
REQ-002 Parameter H_BP, default 128: horizontal back-porch width in pixel clocks.
REQ-003 Parameter H_ACTIVE, default 800: visible pixels per line.
REQ-004 Parameter H_FP, default 24: horizontal front-porch width in pixel clocks.
REQ-005 Parameter HSYNC_POL, default 1: level of hsync during the sync phase (1 = positive pulse).
REQ-006 sys_clk  input  1  system clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 pix_en  input  1  pixel-clock enable; one pulse per pixel period; tie high when sys_clk is the pixel clock.
REQ-009 q1  output  2  current line phase: 00 sync, 01 back porch, 10 active, 11 front porch.
REQ-010 hcnt  output  10  pixel count within the current phase.
REQ-011 hsync  output  1  horizontal sync to the monitor.
REQ-012 hactive  output  1  high while q1 = 10 (visible region).
REQ-013 EndLine  output  1  single sys_clk pulse marking the last pixel of the line; drives the frame scan counter.
REQ-014 xpos  output  10  visible column index, 0..H_ACTIVE-1.

Function
REQ-015 Phase modulus: H_SYNC in 00, H_BP in 01, H_ACTIVE in 10, H_FP in 11; every parameter is 1..1023.
REQ-016 Terminal condition co1 = pix_en AND (hcnt == modulus(q1) - 1).
REQ-017 On co1: hcnt <= 0 and q1 advances 00->01->10->11->00 (wrap from 11 to 00).
REQ-018 On pix_en without co1: hcnt <= hcnt + 1 and q1 holds.
REQ-019 On pix_en = 0: hcnt and q1 hold, and EndLine = 0.
REQ-020 EndLine = co1 AND (q1 == 11), combinational from registered state; it is never high for more than one consecutive sys_clk.
REQ-021 hsync = HSYNC_POL when q1 == 00, otherwise ~HSYNC_POL; hactive = (q1 == 10); both are combinational decodes of the registered q1, with no added latency.
REQ-022 Line period = H_SYNC + H_BP + H_ACTIVE + H_FP pix_en pulses (1024 by default).
REQ-023 A modulus of 1 causes the phase to last exactly one pix_en pulse, with hcnt staying at 0.
REQ-024 hcnt never exceeds modulus(q1) - 1; no wrap past 1023 is possible.

Reset
REQ-025 When reset = 1 at a rising edge, the next state is q1 = 00 and hcnt = 0, overriding pix_en and co1, including in the middle of a line.
REQ-026 Outputs after reset: q1 = 00, hcnt = 0, hsync = HSYNC_POL, hactive = 0, EndLine = 0 (with pix_en = 0 or hcnt < H_SYNC-1), xpos = 0.
REQ-027 The first line after reset release is a full-length line that starts at pixel 0 of the sync phase.

Configuration
REQ-028 Macro HSCAN_XPOS_EN, when defined: xpos = hcnt while q1 == 10, otherwise 0.
REQ-029 Macro HSCAN_XPOS_EN, when undefined: the xpos port still exists and is tied to 10'd0, with no logic behind it; all other behaviour is identical.

Verification
REQ-030 Defaults, pix_en = 1, reset released at cycle 0 -> hsync high for cycles 0..71; hactive high for cycles 200..999; EndLine high only at cycle 1023; next EndLine at cycle 2047.
REQ-031 pix_en alternating 1/0 -> EndLine period of 2048 sys_clk; every EndLine pulse is one cycle wide and coincides with pix_en = 1.
REQ-032 Reset asserted at cycle 500 (q1 = 10, hcnt = 300) for one cycle -> the next cycle shows q1 = 00, hcnt = 0, hsync = 1, and the next EndLine arrives 1024 cycles after release.
REQ-033 H_SYNC = 1, H_FP = 1, pix_en = 1 -> q1 = 00 for exactly 1 cycle and 11 for exactly 1 cycle; EndLine coincides with the single 11 cycle; line period = 930.
REQ-034 With HSCAN_XPOS_EN defined -> xpos = 0 at cycle 200, 799 at cycle 999, and 0 at cycle 1000; without the macro -> xpos = 0 in every cycle.
REQ-035 Connected to the frame scan counter, free-running -> the vertical phase advances every 1024 × line count, and a frame spans 625 EndLine pulses.

Source files
------------

// File: rtl/hscan_ctrl.sv
// hscan_ctrl: horizontal line scan sequencer (sync / back porch / active / front porch).
// Define HSCAN_XPOS_EN to drive xpos with the visible column; otherwise xpos is tied to 0.
module hscan_ctrl #(
  parameter int unsigned H_SYNC    = 72,
  parameter int unsigned H_BP      = 128,
  parameter int unsigned H_ACTIVE  = 800,
  parameter int unsigned H_FP      = 24,
  parameter bit          HSYNC_POL = 1'b1
) (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       pix_en,
  output logic [1:0] q1,
  output logic [9:0] hcnt,
  output logic       hsync,
  output logic       hactive,
  output logic       EndLine,
  output logic [9:0] xpos
);

  typedef enum logic [1:0] {
    PH_SYNC = 2'b00,
    PH_BP   = 2'b01,
    PH_ACT  = 2'b10,
    PH_FP   = 2'b11
  } phase_t;

  localparam logic [9:0] L_SYNC = 10'(H_SYNC - 1);
  localparam logic [9:0] L_BP   = 10'(H_BP - 1);
  localparam logic [9:0] L_ACT  = 10'(H_ACTIVE - 1);
  localparam logic [9:0] L_FP   = 10'(H_FP - 1);

  phase_t     r_q1;
  logic [9:0] r_hcnt;

  phase_t     w_next;
  logic [9:0] w_last;
  logic       w_co1;

  // last count value of the current phase and the phase that follows it
  always_comb begin
    w_last = L_SYNC;
    w_next = PH_BP;
    unique case (r_q1)
      PH_SYNC: begin
        w_last = L_SYNC;
        w_next = PH_BP;
      end
      PH_BP: begin
        w_last = L_BP;
        w_next = PH_ACT;
      end
      PH_ACT: begin
        w_last = L_ACT;
        w_next = PH_FP;
      end
      PH_FP: begin
        w_last = L_FP;
        w_next = PH_SYNC;
      end
    endcase
  end

  assign w_co1 = pix_en && (r_hcnt == w_last);

  // phase FSM and in-phase pixel counter; reset restarts the line at sync pixel 0
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      r_q1   <= PH_SYNC;
      r_hcnt <= '0;
    end else if (pix_en) begin
      if (w_co1) begin
        r_q1   <= w_next;
        r_hcnt <= '0;
      end else begin
        r_hcnt <= r_hcnt + 10'd1;
      end
    end
  end

  assign q1      = r_q1;
  assign hcnt    = r_hcnt;
  assign hsync   = (r_q1 == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
  assign hactive = (r_q1 == PH_ACT);
  assign EndLine = w_co1 && (r_q1 == PH_FP);

`ifdef HSCAN_XPOS_EN
  assign xpos = (r_q1 == PH_ACT) ? r_hcnt : 10'd0;
`else
  assign xpos = 10'd0;
`endif

endmodule

// File: tb/tb_hscan_ctrl.sv
// tb_hscan_ctrl: checks two hscan_ctrl builds (default timing and 1-pixel sync/front porch)
// against a line-position model, plus fixed cycle-number expectations.
module tb_hscan_ctrl;

  localparam int HS  = 72;
  localparam int BP  = 128;
  localparam int HA  = 800;
  localparam int FP  = 24;
  localparam int PER = HS + BP + HA + FP;
  localparam int HS2 = 1;
  localparam int FP2 = 1;
  localparam int PER2 = HS2 + BP + HA + FP2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pen = 1'b0;

  logic [1:0] q1_a, q1_b;
  logic [9:0] hcnt_a, hcnt_b, xpos_a, xpos_b;
  logic hs_a, hs_b, ha_a, ha_b, el_a, el_b;

  int p1, p2, cyc;
  int n_tests = 0;
  int n_fail = 0;
  int mode = 4;
  bit chk_en = 1'b0;
  int last_el = 0;
  int n_el = 0;
  bit xen;

  hscan_ctrl u_a (
    .sys_clk(clk), .reset(rst), .pix_en(pen),
    .q1(q1_a), .hcnt(hcnt_a), .hsync(hs_a), .hactive(ha_a),
    .EndLine(el_a), .xpos(xpos_a)
  );

  hscan_ctrl #(.H_SYNC(HS2), .H_FP(FP2)) u_b (
    .sys_clk(clk), .reset(rst), .pix_en(pen),
    .q1(q1_b), .hcnt(hcnt_b), .hsync(hs_b), .hactive(ha_b),
    .EndLine(el_b), .xpos(xpos_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s at cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // phase and in-phase count from position within the line
  task automatic decode(input int p, input int hs, input int fp,
                        output int ph, output int h);
    if (p < hs) begin
      ph = 0; h = p;
    end else if (p < hs + BP) begin
      ph = 1; h = p - hs;
    end else if (p < hs + BP + HA) begin
      ph = 2; h = p - hs - BP;
    end else begin
      ph = 3; h = p - hs - BP - HA;
    end
    if (fp < 1) ph = -1;
  endtask

  // model: line position advances once per pix_en pulse
  always @(posedge clk) begin
    if (rst) begin
      p1 <= 0; p2 <= 0; cyc <= 0;
    end else begin
      cyc <= cyc + 1;
      if (pen) begin
        p1 <= (p1 + 1) % PER;
        p2 <= (p2 + 1) % PER2;
      end
    end
  end

  // compare on the falling edge
  always @(negedge clk) begin
    int ph, h;
    if (chk_en) begin
      decode(p1, HS, FP, ph, h);
      chk("a_q1", int'(q1_a), ph);
      chk("a_hcnt", int'(hcnt_a), h);
      chk("a_hsync", int'(hs_a), (ph == 0) ? 1 : 0);
      chk("a_hactive", int'(ha_a), (ph == 2) ? 1 : 0);
      chk("a_endline", int'(el_a), (pen && p1 == PER - 1) ? 1 : 0);
      chk("a_xpos", int'(xpos_a), (xen && ph == 2) ? h : 0);
      decode(p2, HS2, FP2, ph, h);
      chk("b_q1", int'(q1_b), ph);
      chk("b_hcnt", int'(hcnt_b), h);
      chk("b_hsync", int'(hs_b), (ph == 0) ? 1 : 0);
      chk("b_hactive", int'(ha_b), (ph == 2) ? 1 : 0);
      chk("b_endline", int'(el_b), (pen && p2 == PER2 - 1) ? 1 : 0);
      chk("b_xpos", int'(xpos_b), (xen && ph == 2) ? h : 0);

      if (mode == 4) begin
        chk("rst_q1", int'(q1_a), 0);
        chk("rst_hcnt", int'(hcnt_a), 0);
        chk("rst_hsync", int'(hs_a), 1);
        chk("rst_hactive", int'(ha_a), 0);
        chk("rst_endline", int'(el_a), 0);
        chk("rst_xpos", int'(xpos_a), 0);
      end

      if (mode == 1) begin
        if (cyc == 71)   chk("lit_hsync71", int'(hs_a), 1);
        if (cyc == 72)   chk("lit_hsync72", int'(hs_a), 0);
        if (cyc == 199)  chk("lit_hact199", int'(ha_a), 0);
        if (cyc == 200)  chk("lit_hact200", int'(ha_a), 1);
        if (cyc == 999)  chk("lit_hact999", int'(ha_a), 1);
        if (cyc == 1000) chk("lit_hact1000", int'(ha_a), 0);
        if (cyc == 1022) chk("lit_el1022", int'(el_a), 0);
        if (cyc == 1023) chk("lit_el1023", int'(el_a), 1);
        if (cyc == 1024) chk("lit_el1024", int'(el_a), 0);
        if (cyc == 2047) chk("lit_el2047", int'(el_a), 1);
        if (cyc == 200)  chk("lit_xpos200", int'(xpos_a), 0);
        if (cyc == 999)  chk("lit_xpos999", int'(xpos_a), xen ? 799 : 0);
        if (cyc == 1000) chk("lit_xpos1000", int'(xpos_a), 0);
        if (cyc == 0)    chk("lit_b_q1_0", int'(q1_b), 0);
        if (cyc == 1)    chk("lit_b_q1_1", int'(q1_b), 1);
        if (cyc == 928)  chk("lit_b_q1_928", int'(q1_b), 2);
        if (cyc == 929)  chk("lit_b_q1_929", int'(q1_b), 3);
        if (cyc == 929)  chk("lit_b_el929", int'(el_b), 1);
        if (cyc == 930)  chk("lit_b_q1_930", int'(q1_b), 0);
        if (cyc == 1859) chk("lit_b_el1859", int'(el_b), 1);
      end

      if (mode == 2 && el_a) begin
        chk("alt_el_pen", int'(pen), 1);
        if (n_el > 0) chk("alt_el_period", cyc - last_el, 2048);
        last_el = cyc;
        n_el++;
      end

      if (mode == 3) begin
        if (rst && cyc == 500) begin
          chk("mid_q1", int'(q1_a), 2);
          chk("mid_hcnt", int'(hcnt_a), 300);
        end
        if (cyc == 0) begin
          chk("mid_post_q1", int'(q1_a), 0);
          chk("mid_post_hsync", int'(hs_a), 1);
        end
        if (cyc == 1023) chk("mid_el1023", int'(el_a), 1);
      end
    end
  end

  initial begin
`ifdef HSCAN_XPOS_EN
    xen = 1'b1;
`else
    xen = 1'b0;
`endif
    rst = 1'b1;
    pen = 1'b0;
    mode = 4;
    @(posedge clk);
    #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    // free-running line from reset release
    mode = 1;
    rst = 1'b0;
    pen = 1'b1;
    repeat (2100) begin
      @(posedge clk);
      #1;
    end
    // alternating pixel enable
    rst = 1'b1;
    pen = 1'b0;
    @(posedge clk);
    #1;
    mode = 2;
    rst = 1'b0;
    pen = 1'b1;
    repeat (4300) begin
      @(posedge clk);
      #1 pen = ~pen;
    end
    chk("alt_el_count", (n_el >= 2) ? 1 : 0, 1);
    // reset pulse in the middle of the active region
    rst = 1'b1;
    pen = 1'b1;
    @(posedge clk);
    #1;
    mode = 3;
    rst = 1'b0;
    repeat (500) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (1100) begin
      @(posedge clk);
      #1;
    end
    // random enable with rare resets
    mode = 0;
    repeat (20000) begin
      @(posedge clk);
      #1;
      pen = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 2999) == 0);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
